// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : keypad_pkg                                                |
// | Purpose  : Shared constants, debounce-state encoding and a 16-bit    |
// |            population-count helper for the keypad scanner.           |
// | Contents : NUM_ROWS, NUM_COLS, KEY_W, COL_RESET, deb_state_t,        |
// |            popcount16()                                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package keypad_pkg;

  localparam int          NUM_ROWS  = 4;
  localparam int          NUM_COLS  = 4;
  localparam int          KEY_W     = 16;
  localparam logic [3:0]  COL_RESET = 4'b1110;

  // Debounce progress: IDLE_CMP before the first completed scan, COUNT while
  // a candidate is accumulating matches, ACCEPT once it has been taken.
  typedef enum logic [1:0] {
    IDLE_CMP = 2'd0,
    COUNT    = 2'd1,
    ACCEPT   = 2'd2
  } deb_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : keypad_scan_if                                            |
// | Purpose  : Key-result bus from the scanner to the downstream digit   |
// |            encoder.                                                  |
// | Signals  : onehot[15:0] debounced key, key_valid new-key strobe,     |
// |            key_multi multiple-key level                              |
// | Modports : master (scanner drives), slave (consumer reads)           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] onehot;
  logic             key_valid;
  logic             key_multi;

  modport master (output onehot, output key_valid, output key_multi);
  modport slave  (input  onehot, input  key_valid, input  key_multi);

endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : key_debounce                                              |
// | Purpose  : Accepts a scan code once it has been seen on              |
// |            DEBOUNCE_SCANS consecutive scans; classifies single vs    |
// |            multiple keys and strobes key_valid on a new key.         |
// | Ports    : clk, rst_n (async active-low), raw[15:0] scan code,       |
// |            scan_done strobe, onehot[15:0], key_valid, key_multi      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [KEY_W-1:0] raw,
  input  wire logic             scan_done,
  output logic      [KEY_W-1:0] onehot,
  output logic                  key_valid,
  output logic                  key_multi
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  deb_state_t       state;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;

  logic             changed;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  // On acceptance the candidate always equals raw (either it just matched,
  // or it was just loaded with a one-scan threshold), so raw is the code
  // taken into onehot.
  always_comb begin
    changed = (raw != cand);
    cnt_inc = cnt + CNT_ONE;
    accept  = 1'b0;
    if (scan_done) begin
      if (changed) begin
        accept = (CNT_MAX == CNT_ONE);
      end else begin
        accept = (cnt < CNT_MAX) && (cnt_inc == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE_CMP;
      cand      <= '0;
      cnt       <= '0;
      onehot    <= '0;
      key_valid <= 1'b0;
      key_multi <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        if (changed) begin
          cand <= raw;
          cnt  <= CNT_ONE;
        end else if (cnt < CNT_MAX) begin
          cnt <= cnt_inc;
        end

        if (accept) begin
          state <= ACCEPT;
          if (popcount16(raw) <= 5'd1) begin
            onehot    <= raw;
            key_multi <= 1'b0;
            key_valid <= (raw != '0) && (raw != onehot);
          end else begin
            onehot    <= '0;
            key_multi <= 1'b1;
          end
        end else if (changed || state == IDLE_CMP) begin
          state <= COUNT;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : keypad_scan                                               |
// | Purpose  : 4x4 active-low key-matrix scanner: drives one column low  |
// |            at a time, synchronises the row returns, assembles a      |
// |            16-bit scan code and hands it to key_debounce.            |
// | Ports    : clk, rst_n (async active-low), row[3:0] (async input),    |
// |            col[3:0] column drive, key_if (master) result bus         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic [NUM_ROWS-1:0] row,
  output logic      [NUM_COLS-1:0] col,
  keypad_scan_if.master            key_if
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [DIV_W-1:0]    div_cnt;
  logic [1:0]          col_idx;
  logic [11:0]         acc;       // columns 0..2; column 3 merges directly
  logic [KEY_W-1:0]    raw_code;
  logic                scan_done;

  logic                tick;

  // Sampling on the last dwell cycle leaves SCAN_DIV-1 cycles for the
  // matrix and the synchroniser to settle after the column change.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta  <= 4'b1111;
      row_sync  <= 4'b1111;
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      col       <= COL_RESET;
      acc       <= '0;
      raw_code  <= '0;
      scan_done <= 1'b0;
    end else begin
      row_meta  <= row;
      row_sync  <= row_meta;
      scan_done <= 1'b0;

      if (tick) begin
        div_cnt <= '0;
        col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
        col_idx <= col_idx + 2'd1;
        case (col_idx)
          2'd0:    acc[3:0]  <= ~row_sync;
          2'd1:    acc[7:4]  <= ~row_sync;
          2'd2:    acc[11:8] <= ~row_sync;
          default: begin
            raw_code  <= {~row_sync, acc};
            scan_done <= 1'b1;
          end
        endcase
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  logic [KEY_W-1:0] deb_onehot;
  logic             deb_valid;
  logic             deb_multi;

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_key_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (raw_code),
    .scan_done (scan_done),
    .onehot    (deb_onehot),
    .key_valid (deb_valid),
    .key_multi (deb_multi)
  );

  assign key_if.onehot    = deb_onehot;
  assign key_if.key_valid = deb_valid;
  assign key_if.key_multi = deb_multi;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_keypad_scan                                            |
// | Purpose  : Directed self-checking bench for keypad_scan with a       |
// |            behavioural key-matrix model (SCAN_DIV=4, 3 scans).       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .row    (row),
    .col    (col),
    .key_if (kif)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[4*c+r]) row[r] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) pulses++;
  end

  task automatic wait_onehot(input logic [15:0] exp, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kif.onehot === exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_multi(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kif.key_multi === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    int bad_col, bad_out;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (col !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col); else n_pass++;
    n_checks++; if (kif.onehot !== 16'h0000) $display("FAIL reset_onehot: got %h expected 0000", kif.onehot); else n_pass++;
    n_checks++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", kif.key_valid); else n_pass++;
    n_checks++; if (kif.key_multi !== 1'b0) $display("FAIL reset_multi: got %b expected 0", kif.key_multi); else n_pass++;
    rst_n = 1'b1;
    bad_col = 0; bad_out = 0;
    for (int k = 0; k < 200; k++) begin
      exp_col = 4'b1110;
      for (int j = 0; j < (k / 4) % 4; j++) exp_col = {exp_col[2:0], exp_col[3]};
      if (col !== exp_col) bad_col++;
      if (kif.onehot !== 16'h0000 || kif.key_valid !== 1'b0) bad_out++;
      @(negedge clk);
    end
    n_checks++; if (bad_col != 0) $display("FAIL col_rotation: got %0d bad cycles expected 0", bad_col); else n_pass++;
    n_checks++; if (bad_out != 0) $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad_out); else n_pass++;
  endtask

  task automatic test_single_press();
    bit ok;
    int base, bad;
    base = pulses;
    keys = 16'h0008;
    wait_onehot(16'h0008, 67, ok);
    n_checks++; if (!ok) $display("FAIL press_latency: got %h expected 0008 within 67 cycles", kif.onehot); else n_pass++;
    @(negedge clk);
    n_checks++; if (pulses - base != 1) $display("FAIL press_pulse: got %0d pulses expected 1", pulses - base); else n_pass++;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (kif.onehot !== 16'h0008) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++; if (pulses - base != 1) $display("FAIL hold_pulses: got %0d pulses expected 1", pulses - base); else n_pass++;
    keys = 16'h0000;
    wait_onehot(16'h0000, 80, ok);
    n_checks++; if (!ok) $display("FAIL release_onehot: got %h expected 0000", kif.onehot); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (pulses - base != 1) $display("FAIL release_pulse: got %0d pulses expected 1", pulses - base); else n_pass++;
  endtask

  task automatic test_bounce();
    bit ok;
    int base, bad;
    base = pulses;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      keys = (((i / 5) % 2) == 0) ? 16'h0020 : 16'h0000;
      @(negedge clk);
      if (kif.onehot !== 16'h0000) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bounce_stable: got %0d changed cycles expected 0", bad); else n_pass++;
    n_checks++; if (pulses != base) $display("FAIL bounce_pulse: got %0d pulses expected 0", pulses - base); else n_pass++;
    keys = 16'h0020;
    wait_onehot(16'h0020, 67, ok);
    n_checks++; if (!ok) $display("FAIL bounce_settle: got %h expected 0020", kif.onehot); else n_pass++;
    @(negedge clk);
    n_checks++; if (pulses - base != 1) $display("FAIL bounce_settle_pulse: got %0d pulses expected 1", pulses - base); else n_pass++;
    keys = 16'h0000;
    wait_onehot(16'h0000, 80, ok);
  endtask

  task automatic test_multi();
    bit ok;
    int base;
    repeat (20) @(negedge clk);
    base = pulses;
    keys = 16'h00C0;
    wait_multi(80, ok);
    n_checks++; if (!ok) $display("FAIL multi_level: got %b expected 1", kif.key_multi); else n_pass++;
    n_checks++; if (kif.onehot !== 16'h0000) $display("FAIL multi_onehot: got %h expected 0000", kif.onehot); else n_pass++;
    n_checks++; if (pulses != base) $display("FAIL multi_pulse: got %0d pulses expected 0", pulses - base); else n_pass++;
    keys = 16'h0040;
    wait_onehot(16'h0040, 80, ok);
    n_checks++; if (!ok) $display("FAIL multi_release_onehot: got %h expected 0040", kif.onehot); else n_pass++;
    n_checks++; if (kif.key_multi !== 1'b0) $display("FAIL multi_release_level: got %b expected 0", kif.key_multi); else n_pass++;
    @(negedge clk);
    n_checks++; if (pulses - base != 1) $display("FAIL multi_release_pulse: got %0d pulses expected 1", pulses - base); else n_pass++;
    keys = 16'h0000;
    wait_onehot(16'h0000, 80, ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    repeat (20) @(negedge clk);
    base = pulses;
    keys = 16'h2000;
    wait_onehot(16'h2000, 80, ok);
    n_checks++; if (!ok) $display("FAIL b2b_first: got %h expected 2000", kif.onehot); else n_pass++;
    repeat (10) @(negedge clk);
    keys = 16'h4000;
    wait_onehot(16'h4000, 80, ok);
    n_checks++; if (!ok) $display("FAIL b2b_second: got %h expected 4000", kif.onehot); else n_pass++;
    @(negedge clk);
    n_checks++; if (pulses - base != 2) $display("FAIL b2b_pulses: got %0d pulses expected 2", pulses - base); else n_pass++;
    keys = 16'h0000;
    wait_onehot(16'h0000, 80, ok);
    repeat (5) @(negedge clk);
    n_checks++; if (!ok || pulses - base != 2) $display("FAIL b2b_release: got onehot %h pulses %0d expected 0000 and 2", kif.onehot, pulses - base); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    keys = 16'h0400;
    wait_onehot(16'h0400, 80, ok);
    n_checks++; if (!ok) $display("FAIL mid_pre_accept: got %h expected 0400", kif.onehot); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col === 4'b1011) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL mid_find_col2: got %b expected 1011", col); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (col !== 4'b1110) $display("FAIL mid_reset_col: got %b expected 1110", col); else n_pass++;
    n_checks++; if (kif.onehot !== 16'h0000) $display("FAIL mid_reset_onehot: got %h expected 0000", kif.onehot); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    base = pulses;
    wait_onehot(16'h0400, 80, ok);
    n_checks++; if (!ok) $display("FAIL mid_reaccept: got %h expected 0400", kif.onehot); else n_pass++;
    @(negedge clk);
    n_checks++; if (pulses - base != 1) $display("FAIL mid_reaccept_pulse: got %0d pulses expected 1", pulses - base); else n_pass++;
    keys = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
